spu_add_arb: RTL
================

# spu_add_arb

Round-robin arbiter and sequencer that shares one external `spu_add_cfg` adder among `NUM_REQ` requesters. It grants at most one operation per enabled cycle and drives the adder's `cfg`, `s_data0` and `s_data1` inputs and its clock enable. A valid/ID shift register matched to the adder latency returns each result with the requester index. The whole pipeline stalls, adder included, under output backpressure.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `LATENCY`, 1: latency of the attached adder, 1..8; must equal the adder's `LATENCY`.
- `DATA_BITS`, 8: operand and result width.
- `ID_BITS`, `$clog2(NUM_REQ)`: requester index width.
- `clk`  in  1  clock; everything is on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `cke`  in  1  global clock enable.
- `s_valid`  in  `NUM_REQ`  per-requester request valid.
- `s_ready`  out  `NUM_REQ`  per-requester grant (one-hot or zero).
- `s_cfg`  in  `NUM_REQ`×4  per-requester adder cfg.
- `s_data0`, `s_data1`  in  `NUM_REQ`×`DATA_BITS`  per-requester operands.
- `add_cke`  out  1  clock enable to the adder.
- `add_cfg`  out  4  cfg to the adder.
- `add_data0`, `add_data1`  out  `DATA_BITS`  operands to the adder.
- `add_result`  in  `DATA_BITS`  adder `m_data`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result accept.
- `m_id`  out  `ID_BITS`  requester index of the result.
- `m_data`  out  `DATA_BITS`  result; combinational passthrough of `add_result`.
- `m_count`  out  `$clog2(LATENCY+1)`  number of operations in flight.

## Operation
- **Advance:** `adv = cke & (~m_valid | m_ready)`. `add_cke = adv`. Nothing registered changes when `adv` is 0.
- **Arbitration:**
  - Register `last` (`ID_BITS`) holds the last granted index.
  - Search starts at `last+1`, wraps modulo `NUM_REQ`, and stops at the first asserted `s_valid`.
  - Grant happens only when `adv` is 1. `s_ready[g]=1` for the granted index `g`; all other bits are 0.
  - On a grant, `last <= g`. With no requests, `last` holds.
- **Request rules:**
  - `s_valid` must not depend on `s_ready`.
  - Once asserted, a requester holds `s_valid`, `s_cfg` and its data stable until `s_ready`.
  - Transfer occurs when `s_valid[i] & s_ready[i]`.
- **Adder drive:**
  - With a grant, `add_cfg`, `add_data0`, `add_data1` carry requester `g`'s `s_cfg`/`s_data0`/`s_data1`, combinationally.
  - With no grant, they are all zero.
- **Tracking pipeline:**
  - `vld[0..LATENCY-1]` and `id[0..LATENCY-1]` are registers.
  - When `adv` is 1: `vld[0] <= grant_any`, `id[0] <= g`, and stage k shifts into stage k+1.
  - A bubble (`vld`=0) is inserted on cycles without a grant.
- **Outputs:**
  - `m_valid = vld[LATENCY-1]`, `m_id = id[LATENCY-1]`.
  - `m_count` = number of set `vld` bits, kept as a registered counter: +1 on a grant, −1 on a `m_valid & m_ready` transfer, unchanged when both or neither occur in the same cycle.
- **Adder function:** the block does not interpret cfg; `cfg[3]` (carry-in) and `cfg[2:0]` pass through untouched.

## Timing
- **Reset** (`reset_n` low, asynchronous):
  - `vld` = 0, so `m_valid` = 0.
  - `id` = 0, `m_id` = 0, `m_count` = 0, `last` = `NUM_REQ`−1 (requester 0 has first priority).
  - `s_ready` = 0 and `add_cke` = 0, forced while `reset_n` is low.
- **Reset mid-operation:** all in-flight results are discarded, with no `m_valid` pulse. Adder contents are ignored because they are never marked valid.
- **Latency:** grant in cycle t gives `m_valid` in cycle t+`LATENCY` when there is no stall. Throughput is one operation per cycle.
- **Stall** (`m_valid` & ~`m_ready`, or `cke`=0):
  - `add_cke` = 0; `m_valid`, `m_id` and `m_data` hold.
  - All `s_ready` = 0; no operation is lost or duplicated.
- **Simultaneous grant and output accept:** pipeline shifts; `m_count` is unchanged.
- **Wrap:** with `last` = `NUM_REQ`−1, the search begins at index 0.
- **Single requester** continuously valid: granted every `adv` cycle.

## Test plan
- **Single request, no stall.** Bench: real `spu_add_cfg` (`LATENCY`=2, `DATA_BITS`=8). Requester 1 presents cfg=0x0, data0=0x10, data1=0x05 at cycle t. Required: `s_ready`=0b0010 at t; `m_valid`, `m_id`=1, `m_data`=0x15 at t+2; `m_count` 1 → 0.
- **Subtract.** Requester 2 presents cfg=0x9 (sub, carry-in), data0=0x10, data1=0x05. Required: `m_data`=0x0B, `m_id`=2.
- **Full contention.** All 4 requesters valid continuously, `m_ready`=1. Required: grants 0,1,2,3,0,1…; `m_id` repeats the same sequence 2 cycles later; `m_count` saturates at 2.
- **Backpressure.** Pipeline full, `m_ready`=0 for 3 cycles. Required: `m_valid`, `m_id`, `m_data` stable; `add_cke`=0; `s_ready`=0. After release, results are delivered in order with no loss.
- **cke and wrap.**
  - `cke`=0 for 2 cycles while requests are pending: no grants, outputs frozen.
  - Then, with `last`=3 and requesters 0 and 3 valid: requester 0 is granted first.
- **Async reset.** Drop `reset_n` with 2 operations in flight. Required: `m_valid`=0, `m_count`=0, `s_ready`=0 immediately. After release with requesters 0 and 2 valid, requester 0 is granted first.

Source files
------------

// File: rtl/spu_add_arb_if.sv
// spu_add_arb_if: requester, result and adder-side buses of the shared-adder arbiter
interface spu_add_arb_if #(
  parameter int NUM_REQ   = 4,
  parameter int LATENCY   = 1,
  parameter int DATA_BITS = 8,
  parameter int ID_BITS   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]                s_valid;
  logic [NUM_REQ-1:0]                s_ready;
  logic [NUM_REQ-1:0][3:0]           s_cfg;
  logic [NUM_REQ-1:0][DATA_BITS-1:0] s_data0;
  logic [NUM_REQ-1:0][DATA_BITS-1:0] s_data1;
  logic                              add_cke;
  logic [3:0]                        add_cfg;
  logic [DATA_BITS-1:0]              add_data0;
  logic [DATA_BITS-1:0]              add_data1;
  logic [DATA_BITS-1:0]              add_result;
  logic                              m_valid;
  logic                              m_ready;
  logic [ID_BITS-1:0]                m_id;
  logic [DATA_BITS-1:0]              m_data;
  logic [$clog2(LATENCY+1)-1:0]      m_count;
  modport slave (
    input  s_valid, s_cfg, s_data0, s_data1, add_result, m_ready,
    output s_ready, add_cke, add_cfg, add_data0, add_data1, m_valid, m_id, m_data, m_count
  );
  modport master (
    output s_valid, s_cfg, s_data0, s_data1, add_result, m_ready,
    input  s_ready, add_cke, add_cfg, add_data0, add_data1, m_valid, m_id, m_data, m_count
  );
endinterface

// File: rtl/spu_add_arb.sv
// spu_add_arb: round-robin sharing of one pipelined adder with a matched valid/ID pipeline
module spu_add_arb #(
  parameter int NUM_REQ   = 4,
  parameter int LATENCY   = 1,
  parameter int DATA_BITS = 8,
  parameter int ID_BITS   = $clog2(NUM_REQ)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cke,
  spu_add_arb_if.slave bus
);
  localparam int CW = $clog2(LATENCY+1);
  logic [ID_BITS-1:0]              last, g;
  logic                            found, adv, gnt, out_xfer;
  logic [LATENCY-1:0]              vld;
  logic [LATENCY-1:0][ID_BITS-1:0] id;
  logic [CW-1:0]                   count;
  // search starts one past the last grant and wraps, so priority rotates
  always_comb begin
    found = 1'b0;
    g = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.s_valid[(int'(last) + k) % NUM_REQ]) begin
        found = 1'b1;
        g = ID_BITS'((int'(last) + k) % NUM_REQ);
      end
    end
  end
  assign adv      = cke & reset_n & (~bus.m_valid | bus.m_ready);
  assign gnt      = adv & found;
  assign out_xfer = adv & bus.m_valid & bus.m_ready;
  assign bus.s_ready   = gnt ? NUM_REQ'(1) << g : '0;
  assign bus.add_cke   = adv;
  assign bus.add_cfg   = gnt ? bus.s_cfg[g] : '0;
  assign bus.add_data0 = gnt ? bus.s_data0[g] : '0;
  assign bus.add_data1 = gnt ? bus.s_data1[g] : '0;
  assign bus.m_valid   = vld[LATENCY-1];
  assign bus.m_id      = id[LATENCY-1];
  assign bus.m_data    = bus.add_result;
  assign bus.m_count   = count;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last  <= ID_BITS'(NUM_REQ - 1);
      vld   <= '0;
      id    <= '0;
      count <= '0;
    end else if (adv) begin
      if (gnt) last <= g;
      vld[0] <= gnt;
      id[0]  <= g;
      for (int k = 1; k < LATENCY; k++) begin
        vld[k] <= vld[k-1];
        id[k]  <= id[k-1];
      end
      count <= count + CW'(gnt) - CW'(out_xfer);
    end
  end
endmodule
